// File: rtl/io_cycle_initiator.sv
// ============================================================================
// io_cycle_initiator
// ----------------------------------------------------------------------------
// Host-side bus master for Dock I/O cycles. It accepts one request at a time
// and runs the bus sequence setup -> strobe -> wait -> release -> recover,
// while honouring ready_n stretching from the address decoder. Read data is
// captured when ready_n returns high, and exactly one response pulse is
// produced per request.
//
// Optional feature macro: IOC_TIMEOUT_EN
//   defined   : a WAIT phase with ready_n low for TIMEOUT_CYC edges is aborted
//               and the response carries rsp_timeout=1.
//   undefined : no wait counter; WAIT holds until ready_n=1; rsp_timeout is 0.
//
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready = (state == IDLE)
//   req_addr/req_write/req_wdata   request payload, latched on accept
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata/rsp_timeout response payload, held until the next accept
//   addr, iorq_n, r_w_    I/O bus address, strobe (active low), 1=read
//   dout, dout_oe         write data to the bus and its drive enable
//   din, ready_n          read data from the bus, decoder completion (1=done)
// ============================================================================
module io_cycle_initiator #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 16,
    parameter int IDLE_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] addr,
    output logic              iorq_n,
    output logic              r_w_,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    input  logic [DATA_W-1:0] din,
    input  logic              ready_n
);

    localparam int SCW = $clog2(SETUP_CYC + 1);
    localparam int ICW = $clog2(IDLE_CYC + 1);
    localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);
    localparam logic [ICW-1:0] IDLE_LAST  = ICW'(IDLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [SCW-1:0]    setup_cnt_r;
    logic [ICW-1:0]    idle_cnt_r;
    logic              accept_s;
    logic              setup_done_s;
    logic              idle_done_s;
    logic              timeout_s;

    // Next values of the registered bus/response outputs.
    logic [ADDR_W-1:0] addr_s;
    logic              iorq_n_s;
    logic              r_w_s;
    logic [DATA_W-1:0] dout_s;
    logic              dout_oe_s;
    logic              rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_s;
    logic              rsp_timeout_s;

    logic [ADDR_W-1:0] addr_r;
    logic              iorq_n_r;
    logic              r_w_r;
    logic [DATA_W-1:0] dout_r;
    logic              dout_oe_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_timeout_r;

    assign req_ready    = (state_r == ST_IDLE);
    assign accept_s     = req_valid & req_ready;
    assign setup_done_s = (setup_cnt_r == SETUP_LAST);
    assign idle_done_s  = (idle_cnt_r == IDLE_LAST);

`ifdef IOC_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

    logic [WCW-1:0] wait_cnt_r;

    // The abort fires on the edge that would make the count reach TIMEOUT_CYC.
    assign timeout_s = ~ready_n & (wait_cnt_r == WAIT_LAST);

    // Wait-edge counter: cleared on accept (entry to SETUP), counts stretched WAIT edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WCW{1'b0}};
        end else if (accept_s) begin
            wait_cnt_r <= {WCW{1'b0}};
        end else if ((state_r == ST_WAIT) && !ready_n && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register plus the setup and recovery phase counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            setup_cnt_r <= {SCW{1'b0}};
            idle_cnt_r  <= {ICW{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == ST_SETUP) && !setup_done_s) begin
                setup_cnt_r <= setup_cnt_r + {{(SCW-1){1'b0}}, 1'b1};
            end else begin
                setup_cnt_r <= {SCW{1'b0}};
            end
            if ((state_r == ST_RECOVER) && !idle_done_s) begin
                idle_cnt_r <= idle_cnt_r + {{(ICW-1){1'b0}}, 1'b1};
            end else begin
                idle_cnt_r <= {ICW{1'b0}};
            end
        end
    end

    // Next-state logic for the bus cycle sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (setup_done_s) begin
                    state_s = ST_ASSERT;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            // The decoder still shows its idle ready_n=1 here, so it is ignored.
            ST_ASSERT: state_s = ST_WAIT;
            ST_WAIT: begin
                if (ready_n || timeout_s) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RELEASE: state_s = ST_RECOVER;
            ST_RECOVER: begin
                if (idle_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RECOVER;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered bus and response outputs.
    always_comb begin
        addr_s        = addr_r;
        iorq_n_s      = iorq_n_r;
        r_w_s         = r_w_r;
        dout_s        = dout_r;
        dout_oe_s     = dout_oe_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            ST_IDLE: begin
                iorq_n_s = 1'b1;
                if (accept_s) begin
                    addr_s        = req_addr;
                    r_w_s         = ~req_write;
                    dout_s        = req_wdata;
                    dout_oe_s     = req_write;
                    rsp_rdata_s   = {DATA_W{1'b0}};
                    rsp_timeout_s = 1'b0;
                end else begin
                    r_w_s     = 1'b1;
                    dout_oe_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (setup_done_s) begin
                    iorq_n_s = 1'b0;
                end else begin
                    iorq_n_s = 1'b1;
                end
            end
            ST_ASSERT: iorq_n_s = 1'b0;
            ST_WAIT: begin
                if (ready_n) begin
                    iorq_n_s      = 1'b1;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = r_w_r ? din : {DATA_W{1'b0}};
                    rsp_timeout_s = 1'b0;
                end else if (timeout_s) begin
                    iorq_n_s      = 1'b1;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = {DATA_W{1'b0}};
                    rsp_timeout_s = 1'b1;
                end else begin
                    iorq_n_s = 1'b0;
                end
            end
            // Strobe is already high; drop write drive and return r_w_ to read.
            ST_RELEASE, ST_RECOVER: begin
                iorq_n_s  = 1'b1;
                r_w_s     = 1'b1;
                dout_oe_s = 1'b0;
            end
            default: begin
                iorq_n_s  = 1'b1;
                r_w_s     = 1'b1;
                dout_oe_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset releases the strobe and bus drive immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= {ADDR_W{1'b0}};
            iorq_n_r      <= 1'b1;
            r_w_r         <= 1'b1;
            dout_r        <= {DATA_W{1'b0}};
            dout_oe_r     <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_timeout_r <= 1'b0;
        end else begin
            addr_r        <= addr_s;
            iorq_n_r      <= iorq_n_s;
            r_w_r         <= r_w_s;
            dout_r        <= dout_s;
            dout_oe_r     <= dout_oe_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign addr        = addr_r;
    assign iorq_n      = iorq_n_r;
    assign r_w_        = r_w_r;
    assign dout        = dout_r;
    assign dout_oe     = dout_oe_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_io_cycle_initiator.sv
// ============================================================================
// tb_io_cycle_initiator
// Directed bench for io_cycle_initiator (default parameters) paired with a
// small addr_decoder model that stretches ready_n by a programmable number of
// WAIT edges or holds it low indefinitely.
// ============================================================================
module tb_io_cycle_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic       req_write;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic [7:0] addr;
    logic       iorq_n;
    logic       r_w_;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] din = 8'h00;
    logic       ready_n = 1'b1;

    int checks = 0;
    int errors = 0;

    // Decoder model controls
    int         stretch = 0;
    bit         stuck = 1'b0;
    logic [7:0] rd_val = 8'h00;
    int         dcnt = 0;

    // Bus monitor state
    int         low_cnt = 0;
    int         hi_cnt = 0;
    int         last_gap = 0;
    int         strobes = 0;
    int         rsp_cnt = 0;
    bit         unstable = 1'b0;
    logic       prev_iorq = 1'b1;
    logic [7:0] low_addr = 8'h00;
    logic       low_rw = 1'b1;
    logic [7:0] low_dout = 8'h00;
    logic       low_oe = 1'b0;

    io_cycle_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_), .dout(dout), .dout_oe(dout_oe),
        .din(din), .ready_n(ready_n)
    );

    always #5 clk = ~clk;

    // Decoder model: ready_n idles at 1, drops after the strobe is seen, and
    // returns to 1 (with read data) after 'stretch' low edges unless stuck.
    always @(posedge clk) begin
        if (iorq_n) begin
            ready_n <= 1'b1;
            dcnt    <= 0;
            din     <= 8'h00;
        end else if (stuck) begin
            ready_n <= 1'b0;
            din     <= 8'hEE;
        end else if (dcnt < stretch) begin
            ready_n <= 1'b0;
            dcnt    <= dcnt + 1;
            din     <= 8'hEE;
        end else begin
            ready_n <= 1'b1;
            din     <= rd_val;
        end
    end

    // Monitor sampled 2 ns after each rising edge: strobe length, gap between
    // strobes, bus stability while strobed, and response pulse count.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!iorq_n) begin
                if (prev_iorq) begin
                    low_addr = addr;
                    low_rw   = r_w_;
                    low_dout = dout;
                    low_oe   = dout_oe;
                    last_gap = hi_cnt;
                    low_cnt  = 0;
                    strobes  = strobes + 1;
                end else if (addr !== low_addr || r_w_ !== low_rw ||
                             dout !== low_dout || dout_oe !== low_oe) begin
                    unstable = 1'b1;
                end
                low_cnt = low_cnt + 1;
                hi_cnt  = 0;
            end else begin
                hi_cnt = hi_cnt + 1;
            end
            if (rsp_valid) rsp_cnt = rsp_cnt + 1;
            prev_iorq = iorq_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic w, input logic [7:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    bit got;
    int busy;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        req_write = 1'b0;
        req_wdata = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_iorq_n", iorq_n, 1);
        chk("rst_r_w_", r_w_, 1);
        chk("rst_addr", addr, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_oe", dout_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read 0x10, immediate ready
        rd_val = 8'hA5; stretch = 0; rsp_cnt = 0; unstable = 1'b0;
        issue(8'h10, 1'b0, 8'h00);
        wait_rsp(64, got);
        chk("rd_rsp_seen", got, 1);
        chk("rd_rdata", rsp_rdata, 8'hA5);
        chk("rd_timeout", rsp_timeout, 0);
        chk("rd_low_cycles", low_cnt, 2);
        chk("rd_r_w_", low_rw, 1);
        chk("rd_addr", low_addr, 8'h10);
        repeat (3) @(negedge clk);
        chk("rd_one_rsp", rsp_cnt, 1);
        chk("rd_rdata_hold", rsp_rdata, 8'hA5);

        // Write 0x23 <- 0x5A
        rsp_cnt = 0; unstable = 1'b0;
        issue(8'h23, 1'b1, 8'h5A);
        wait_rsp(64, got);
        chk("wr_rsp_seen", got, 1);
        chk("wr_rdata", rsp_rdata, 8'h00);
        chk("wr_low_cycles", low_cnt, 2);
        chk("wr_r_w_", low_rw, 0);
        chk("wr_dout_oe", low_oe, 1);
        chk("wr_dout", low_dout, 8'h5A);
        chk("wr_stable", unstable, 0);
        repeat (2) @(negedge clk);
        chk("wr_r_w_after", r_w_, 1);
        chk("wr_dout_oe_after", dout_oe, 0);

        // Stretch: 3 extra WAIT edges with ready_n=0
        rd_val = 8'hC3; stretch = 3; rsp_cnt = 0; unstable = 1'b0;
        issue(8'h41, 1'b0, 8'h00);
        wait_rsp(64, got);
        chk("st_rsp_seen", got, 1);
        chk("st_low_cycles", low_cnt, 5);
        chk("st_rdata", rsp_rdata, 8'hC3);
        chk("st_addr", low_addr, 8'h41);
        chk("st_stable", unstable, 0);
        stretch = 0;
        repeat (3) @(negedge clk);

        // Hung decoder
        rsp_cnt = 0; stuck = 1'b1; rd_val = 8'h3C;
`ifdef IOC_TIMEOUT_EN
        issue(8'h50, 1'b0, 8'h00);
        wait_rsp(64, got);
        stuck = 1'b0;
        chk("to_rsp_seen", got, 1);
        chk("to_timeout", rsp_timeout, 1);
        chk("to_rdata", rsp_rdata, 8'h00);
        chk("to_low_cycles", low_cnt, 17);
        chk("to_iorq_n", iorq_n, 1);
`else
        issue(8'h50, 1'b0, 8'h00);
        repeat (64) @(negedge clk);
        chk("nt_iorq_low", iorq_n, 0);
        chk("nt_no_rsp", rsp_cnt, 0);
        stuck = 1'b0;
        wait_rsp(64, got);
        chk("nt_rsp_seen", got, 1);
        chk("nt_timeout", rsp_timeout, 0);
        chk("nt_rdata", rsp_rdata, 8'h3C);
`endif
        repeat (3) @(negedge clk);

        // Back-to-back with req_valid held
        rsp_cnt = 0; strobes = 0; stretch = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h30; req_write = 1'b0; req_wdata = 8'h00;
        @(negedge clk);
        chk("b2b_busy_accept", req_ready, 0);
        req_addr = 8'h31;
        busy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!req_ready) busy = busy + 1;
        end
        chk("b2b_busy_cycles", busy, 4);
        @(negedge clk);
        chk("b2b_ready_again", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_second_accept", req_ready, 0);
        wait_rsp(64, got);
        chk("b2b_rsp_seen", got, 1);
        chk("b2b_rsp_count", rsp_cnt, 2);
        chk("b2b_strobes", strobes, 2);
        chk("b2b_gap", last_gap, 4);
        chk("b2b_addr2", low_addr, 8'h31);
        repeat (3) @(negedge clk);

        // Reset asserted mid-WAIT
        stuck = 1'b1;
        issue(8'h55, 1'b1, 8'h77);
        repeat (3) @(negedge clk);
        chk("rw_in_wait", iorq_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_iorq_n", iorq_n, 1);
        chk("rw_r_w_", r_w_, 1);
        chk("rw_dout_oe", dout_oe, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        stuck = 1'b0; rsp_cnt = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rw_no_rsp", rsp_cnt, 0);

        // Normal read after reset release
        rd_val = 8'h99;
        issue(8'h66, 1'b0, 8'h00);
        wait_rsp(64, got);
        chk("ar_rsp_seen", got, 1);
        chk("ar_rdata", rsp_rdata, 8'h99);
        chk("ar_low_cycles", low_cnt, 2);
        chk("ar_addr", low_addr, 8'h66);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
